// File: rtl/inbuf_feed_pkg.sv
// Shared types and helpers for the input-buffer feed controller.
//   feed_state_e : controller FSM states
//   ptr_w()      : row-pointer width, at least 1 bit even for a single row
package inbuf_feed_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } feed_state_e;

    // Width of a pointer that indexes n rows.
    function automatic int unsigned ptr_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a counter that must reach depth + rows - 1; never below kw + 1.
    function automatic int unsigned drain_w(input int unsigned depth, input int unsigned rows,
                                            input int unsigned kw);
        int unsigned w;
        w = $clog2(depth + rows);
        return (w > kw + 1) ? w : kw + 1;
    endfunction

endpackage

// File: rtl/feed_rr_ptr.sv
// Round-robin row pointer for tile loading.
// Advances the row on each accepted beat, carries into the column on wrap,
// and flags the terminal beat (last row of column K-1).
//   clk, rstn : clock, async active-low reset
//   clr       : synchronous clear to row 0 / column 0
//   adv       : advance on an accepted beat
//   k_cur     : latched tile width K (>= 1 while advancing)
//   rptr      : current row pointer
//   last_c    : current beat is the final beat of the tile
module feed_rr_ptr
    import inbuf_feed_pkg::*;
#(
    parameter  int unsigned ROWS = 4,
    parameter  int unsigned KW   = 5,
    localparam int unsigned RW   = ptr_w(ROWS)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          adv,
    input  logic [KW-1:0] k_cur,
    output logic [RW-1:0] rptr,
    output logic          last_c
);

    logic [KW-1:0] col;
    logic          row_wrap_c;

    assign row_wrap_c = (rptr == RW'(ROWS - 1));
    assign last_c     = row_wrap_c && (col == KW'(k_cur - KW'(1)));

    // Row pointer with column carry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rptr <= '0;
            col  <= '0;
        end else if (clr) begin
            rptr <= '0;
            col  <= '0;
        end else if (adv) begin
            if (row_wrap_c) begin
                rptr <= '0;
                col  <= col + KW'(1);
            end else begin
                rptr <= rptr + RW'(1);
            end
        end
    end

endmodule

// File: rtl/inbuf_feed_ctrl.sv
// Input-buffer feed controller for one systolic-array edge.
// Loads a K-column tile (column-major, valid/ready) into ROWS skewing row
// buffers, waits one settle cycle, then drains all buffers in lock-step for
// K+ROWS-1 cycles so the array sees a diagonal wavefront. Pulses done per tile.
// Optional macro INBUF_FEED_CHECK_EN enables a sticky drain-end non-empty check
// on err; otherwise err is tied low. Port list is the same either way.
//   clk, rstn   : clock, async active-low reset
//   start/k_len : tile request, sampled in IDLE only (K clamped to DEPTH)
//   in_valid/in_ready/in_data : input beat stream
//   buf_write/buf_din  : registered one-hot write strobe + shared write data
//   buf_read/feed_valid: common read strobe / array-side valid
//   buf_empty   : per-row empty flags
//   busy, done, err : status
module inbuf_feed_ctrl
    import inbuf_feed_pkg::*;
#(
    parameter int unsigned ROWS  = 4,
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned KW    = $clog2(DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [KW-1:0]   k_len,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic [ROWS-1:0] buf_write,
    output logic [DW-1:0]   buf_din,
    output logic            buf_read,
    input  logic [ROWS-1:0] buf_empty,
    output logic            feed_valid,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int unsigned RW  = ptr_w(ROWS);
    localparam int unsigned DCW = drain_w(DEPTH, ROWS, KW);

    feed_state_e    state, state_nxt;
    logic [KW-1:0]  k_lat;
    logic [KW-1:0]  k_clamp_c;
    logic [DCW-1:0] dcnt;
    logic [DCW-1:0] drain_len_c;
    logic [RW-1:0]  rptr;
    logic           last_c;
    logic           start_acc_c;
    logic           beat_c;
    logic           drain_last_c;

    assign k_clamp_c    = (k_len > KW'(DEPTH)) ? KW'(DEPTH) : k_len;
    assign start_acc_c  = (state == IDLE) && start;
    assign beat_c       = in_valid && in_ready;
    assign drain_len_c  = DCW'(k_lat) + DCW'(ROWS - 1);
    assign drain_last_c = (dcnt == DCW'(drain_len_c - DCW'(1)));

    feed_rr_ptr #(
        .ROWS (ROWS),
        .KW   (KW)
    ) u_rr_ptr (
        .clk    (clk),
        .rstn   (rstn),
        .clr    (start_acc_c),
        .adv    (beat_c),
        .k_cur  (k_lat),
        .rptr   (rptr),
        .last_c (last_c)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        buf_read   = 1'b0;
        feed_valid = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (k_clamp_c == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && last_c) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                state_nxt = DRAIN;
            end
            DRAIN: begin
                buf_read   = 1'b1;
                feed_valid = 1'b1;
                if (drain_last_c) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Tile width latch.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            k_lat <= '0;
        end else if (start_acc_c) begin
            k_lat <= k_clamp_c;
        end
    end

    // Drain cycle counter, zero outside DRAIN.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dcnt <= '0;
        end else if (state == DRAIN) begin
            dcnt <= dcnt + DCW'(1);
        end else begin
            dcnt <= '0;
        end
    end

    // Registered write strobe and data, one cycle behind the accepted beat.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            buf_write <= '0;
            buf_din   <= '0;
        end else if (beat_c) begin
            buf_write <= ROWS'(1) << rptr;
            buf_din   <= in_data;
        end else begin
            buf_write <= '0;
        end
    end

`ifdef INBUF_FEED_CHECK_EN
    // Sticky error: a buffer still holds data once the drain has finished.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err <= 1'b0;
        end else if (start_acc_c) begin
            err <= 1'b0;
        end else if ((state == DONE) && (buf_empty != '1)) begin
            err <= 1'b1;
        end
    end
`else
    // Empty flags are only observed by the drain check.
    assign err = 1'b0 & (&buf_empty);
`endif

endmodule
